image_gallery_ctrl: RTL and testbench

Gallery controller downstream of the button/switch debouncer. It consumes the 2-bit `image_index` and the one-cycle `delete_flag` pulse, and tracks which of the four image slots are still valid. It presents the selected slot and its frame-buffer base address to the display path. On delete it invalidates the current slot and, when compiled in, zeroes that slot's frame-buffer region through a handshaked write port.

---
 rtl/image_gallery_ctrl_if.sv | 14 +
 rtl/image_gallery_ctrl.sv | 99 +++++++++
 tb/tb_image_gallery_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/image_gallery_ctrl_if.sv
// Frame-buffer write port between the gallery controller and the frame-buffer memory.
// The controller drives the write side; the memory returns mem_ready.
interface image_gallery_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 12
);
    logic              mem_we;
    logic [ADDR_W+1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;

    modport master (output mem_we, mem_waddr, mem_wdata, input mem_ready);
    modport slave  (input mem_we, mem_waddr, mem_wdata, output mem_ready);
endinterface

// File: rtl/image_gallery_ctrl.sv
// Gallery controller: display slot select, per-slot valid tracking and delete sequencing.
// Define GALLERY_ERASE_EN to zero a deleted slot's frame-buffer region through the write port.
module image_gallery_ctrl #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        image_index,
    input  logic              delete_flag,
    output logic [1:0]        display_slot,
    output logic              display_valid,
    output logic [ADDR_W+1:0] base_addr,
    output logic [3:0]        valid_mask,
    output logic              busy,
    output logic              delete_done,
    image_gallery_ctrl_if.master wr
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_valid_mask;
    logic [1:0] r_display_slot;
    logic       w_accept;

    assign w_accept = (r_state == S_IDLE) && delete_flag && r_valid_mask[image_index];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_display_slot <= 2'd0;
        else       r_display_slot <= image_index;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_valid_mask <= 4'b1111;
        else if (w_accept) r_valid_mask[image_index] <= 1'b0;
    end

`ifdef GALLERY_ERASE_EN
    logic [1:0]        r_del_slot;
    logic [ADDR_W-1:0] r_erase_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_del_slot  <= 2'd0;
            r_erase_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_del_slot <= image_index;
                        r_state    <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    // Counter wraps to 0 on the last accepted write, ready for the next delete.
                    if (wr.mem_ready) begin
                        r_erase_cnt <= r_erase_cnt + ADDR_W'(1);
                        if (&r_erase_cnt) r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr.mem_we    = (r_state == S_ERASE);
    assign wr.mem_waddr = {r_del_slot, r_erase_cnt};
`else
    logic w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wr.mem_we    = 1'b0;
    assign wr.mem_waddr = '0;
    assign w_unused     = wr.mem_ready;
`endif

    assign wr.mem_wdata    = {DATA_W{1'b0}};
    assign display_slot    = r_display_slot;
    assign display_valid   = r_valid_mask[r_display_slot];
    assign base_addr       = {r_display_slot, {ADDR_W{1'b0}}};
    assign valid_mask      = r_valid_mask;
    assign busy            = (r_state != S_IDLE);
    assign delete_done     = (r_state == S_DONE);
endmodule

// File: tb/tb_image_gallery_ctrl.sv
// Directed bench for image_gallery_ctrl with ADDR_W=4 (16-word slots).
// Expectations follow whichever GALLERY_ERASE_EN setting the bench is compiled with.
module tb_image_gallery_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 12;

    logic              clk;
    logic              reset;
    logic [1:0]        image_index;
    logic              delete_flag;
    logic [1:0]        display_slot;
    logic              display_valid;
    logic [ADDR_W+1:0] base_addr;
    logic [3:0]        valid_mask;
    logic              busy;
    logic              delete_done;
    logic [3:0]        exp_mask;
    int                checks;
    int                failures;

    image_gallery_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    image_gallery_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .image_index   (image_index),
        .delete_flag   (delete_flag),
        .display_slot  (display_slot),
        .display_valid (display_valid),
        .base_addr     (base_addr),
        .valid_mask    (valid_mask),
        .busy          (busy),
        .delete_done   (delete_done),
        .wr            (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; image_index = 2'd0; delete_flag = 1'b0; mem_if.mem_ready = 1'b1;
        tick(); tick();
        checks++; if (valid_mask !== 4'b1111) begin failures++; $display("FAIL reset_mask got %b exp 1111", valid_mask); end
        checks++; if (busy !== 1'b0 || delete_done !== 1'b0 || mem_if.mem_we !== 1'b0) begin failures++; $display("FAIL reset_ctrl got busy=%b done=%b we=%b exp 0 0 0", busy, delete_done, mem_if.mem_we); end
        checks++; if (mem_if.mem_waddr !== 6'h00) begin failures++; $display("FAIL reset_waddr got %h exp 00", mem_if.mem_waddr); end
        checks++; if (display_slot !== 2'd0 || base_addr !== 6'h00 || display_valid !== 1'b1) begin failures++; $display("FAIL reset_disp got slot=%0d base=%h valid=%b exp 0 00 1", display_slot, base_addr, display_valid); end
        reset = 1'b0;
        exp_mask = 4'b1111;
        tick();
    endtask

    task automatic test_display();
        image_index = 2'd2;
        #1;
        checks++; if (display_slot !== 2'd0) begin failures++; $display("FAIL disp_lag got %0d exp 0", display_slot); end
        tick();
        checks++; if (display_slot !== 2'd2) begin failures++; $display("FAIL disp_slot got %0d exp 2", display_slot); end
        checks++; if (base_addr !== 6'h20) begin failures++; $display("FAIL disp_base got %h exp 20", base_addr); end
        checks++; if (display_valid !== 1'b1 || valid_mask !== 4'b1111) begin failures++; $display("FAIL disp_valid got valid=%b mask=%b exp 1 1111", display_valid, valid_mask); end
    endtask

`ifdef GALLERY_ERASE_EN
    task automatic test_erase();
        int cyc, writes, dones;
        logic [ADDR_W+1:0] ea;
        image_index = 2'd1; delete_flag = 1'b1; mem_if.mem_ready = 1'b1;
        tick();
        delete_flag = 1'b0;
        exp_mask = 4'b1101;
        checks++; if (valid_mask !== exp_mask) begin failures++; $display("FAIL erase_mask got %b exp %b", valid_mask, exp_mask); end
        checks++; if (busy !== 1'b1 || mem_if.mem_we !== 1'b1 || mem_if.mem_waddr !== 6'h10) begin failures++; $display("FAIL erase_start got busy=%b we=%b addr=%h exp 1 1 10", busy, mem_if.mem_we, mem_if.mem_waddr); end
        checks++; if (mem_if.mem_wdata !== 12'h000) begin failures++; $display("FAIL erase_wdata got %h exp 000", mem_if.mem_wdata); end
        cyc = 0; writes = 0; dones = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (delete_done === 1'b1) dones++;
            if (mem_if.mem_we === 1'b1) begin
                ea = 6'h10 + 6'(writes);
                checks++; if (mem_if.mem_waddr !== ea) begin failures++; $display("FAIL erase_addr got %h exp %h", mem_if.mem_waddr, ea); end
                writes++;
            end
            tick();
        end
        checks++; if (cyc != 17) begin failures++; $display("FAIL erase_busy_len got %0d exp 17", cyc); end
        checks++; if (writes != 16) begin failures++; $display("FAIL erase_writes got %0d exp 16", writes); end
        checks++; if (dones != 1) begin failures++; $display("FAIL erase_done got %0d exp 1", dones); end
    endtask

    task automatic test_stall();
        int cyc, writes, dones, stall;
        bit did_stall;
        logic [ADDR_W+1:0] ea;
        image_index = 2'd2; delete_flag = 1'b1; mem_if.mem_ready = 1'b1;
        tick();
        delete_flag = 1'b0;
        exp_mask = 4'b1001;
        cyc = 0; writes = 0; dones = 0; stall = 0; did_stall = 1'b0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (delete_done === 1'b1) dones++;
            // A delete request for slot 3 mid-erase must be dropped; the display still follows.
            delete_flag = (cyc == 3);
            if (cyc == 3) image_index = 2'd3;
            if (mem_if.mem_we === 1'b1) begin
                ea = 6'h20 + 6'(writes);
                checks++; if (mem_if.mem_waddr !== ea) begin failures++; $display("FAIL stall_addr got %h exp %h", mem_if.mem_waddr, ea); end
                if (!did_stall && writes == 5) begin did_stall = 1'b1; stall = 3; end
            end
            mem_if.mem_ready = (stall == 0);
            if (stall > 0) begin
                checks++; if (mem_if.mem_we !== 1'b1) begin failures++; $display("FAIL stall_hold_we got %b exp 1", mem_if.mem_we); end
                stall--;
            end else if (mem_if.mem_we === 1'b1) begin
                writes++;
            end
            tick();
        end
        mem_if.mem_ready = 1'b1; delete_flag = 1'b0;
        checks++; if (cyc != 20) begin failures++; $display("FAIL stall_busy_len got %0d exp 20", cyc); end
        checks++; if (writes != 16) begin failures++; $display("FAIL stall_writes got %0d exp 16", writes); end
        checks++; if (dones != 1) begin failures++; $display("FAIL stall_done got %0d exp 1", dones); end
        checks++; if (valid_mask !== exp_mask) begin failures++; $display("FAIL stall_mask got %b exp %b", valid_mask, exp_mask); end
        checks++; if (display_slot !== 2'd3 || display_valid !== 1'b1) begin failures++; $display("FAIL stall_disp got slot=%0d valid=%b exp 3 1", display_slot, display_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        image_index = 2'd0; delete_flag = 1'b1; mem_if.mem_ready = 1'b1;
        tick();
        delete_flag = 1'b0;
        n = 0;
        while (!(mem_if.mem_we === 1'b1 && mem_if.mem_waddr === 6'h07) && n < 50) begin
            tick(); n++;
        end
        checks++; if (n >= 50) begin failures++; $display("FAIL rmid_reach got timeout exp addr 07"); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_if.mem_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got we=%b busy=%b exp 0 0", mem_if.mem_we, busy); end
        checks++; if (valid_mask !== 4'b1111) begin failures++; $display("FAIL rmid_mask got %b exp 1111", valid_mask); end
        checks++; if (mem_if.mem_waddr !== 6'h00) begin failures++; $display("FAIL rmid_waddr got %h exp 00", mem_if.mem_waddr); end
        @(negedge clk);
        reset = 1'b0;
        exp_mask = 4'b1111;
        tick();
    endtask
`else
    task automatic test_no_erase();
        image_index = 2'd0; delete_flag = 1'b1;
        tick();
        delete_flag = 1'b0;
        exp_mask = 4'b1110;
        checks++; if (valid_mask !== exp_mask) begin failures++; $display("FAIL noer_mask got %b exp %b", valid_mask, exp_mask); end
        checks++; if (busy !== 1'b1 || delete_done !== 1'b1 || mem_if.mem_we !== 1'b0) begin failures++; $display("FAIL noer_done got busy=%b done=%b we=%b exp 1 1 0", busy, delete_done, mem_if.mem_we); end
        image_index = 2'd1; delete_flag = 1'b1;
        tick();
        delete_flag = 1'b0;
        checks++; if (busy !== 1'b0 || delete_done !== 1'b0 || mem_if.mem_we !== 1'b0) begin failures++; $display("FAIL noer_idle got busy=%b done=%b we=%b exp 0 0 0", busy, delete_done, mem_if.mem_we); end
        checks++; if (valid_mask !== exp_mask || mem_if.mem_waddr !== 6'h00) begin failures++; $display("FAIL noer_drop got mask=%b addr=%h exp %b 00", valid_mask, mem_if.mem_waddr, exp_mask); end
    endtask
`endif

    task automatic test_ignored(input logic [1:0] slot);
        image_index = slot; delete_flag = 1'b1;
        tick();
        delete_flag = 1'b0;
        checks++; if (busy !== 1'b0 || delete_done !== 1'b0) begin failures++; $display("FAIL ign_state got busy=%b done=%b exp 0 0", busy, delete_done); end
        checks++; if (valid_mask !== exp_mask) begin failures++; $display("FAIL ign_mask got %b exp %b", valid_mask, exp_mask); end
        checks++; if (display_slot !== slot || display_valid !== 1'b0) begin failures++; $display("FAIL ign_disp got slot=%0d valid=%b exp %0d 0", display_slot, display_valid, slot); end
    endtask

    task automatic do_delete(input int s);
        int n;
        image_index = 2'(s); delete_flag = 1'b1;
        tick();
        delete_flag = 1'b0;
        exp_mask[s] = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL del_timeout got busy=%b exp 0", busy); end
        checks++; if (valid_mask !== exp_mask) begin failures++; $display("FAIL del_mask got %b exp %b", valid_mask, exp_mask); end
    endtask

    task automatic test_all_deleted();
        for (int s = 0; s < 4; s++) if (exp_mask[s]) do_delete(s);
        for (int s = 0; s < 4; s++) begin
            image_index = 2'(s);
            tick();
            checks++; if (display_valid !== 1'b0) begin failures++; $display("FAIL alldel_valid got %b exp 0 at slot %0d", display_valid, s); end
        end
        reset = 1'b1;
        #1;
        checks++; if (valid_mask !== 4'b1111) begin failures++; $display("FAIL revalidate got %b exp 1111", valid_mask); end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_display();
`ifdef GALLERY_ERASE_EN
        test_erase();
        test_stall();
        test_ignored(2'd1);
        test_reset_mid();
`else
        test_no_erase();
        test_ignored(2'd0);
`endif
        test_all_deleted();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
